// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address field helpers for the
// CPU-side cache responder.
package cache_pkg;

  localparam int unsigned TAG_W      = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 5;
  localparam int unsigned ADDR_W     = TAG_W + IDX_W + OFF_W;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned NUM_LINES  = 8;
  localparam int unsigned RAM_AW     = IDX_W + OFF_W;
  localparam int unsigned RAM_DEPTH  = LINE_BYTES * NUM_LINES;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    SERVE
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[OFF_W+IDX_W +: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/cpu_req_responder_if.sv
// CPU request bus plus byte-serial memory port of the cache responder.
//   slave  : the responder (samples CPU request and mem_dout, drives the rest)
//   master : CPU request generator and memory model
interface cpu_req_responder_if;
  import cache_pkg::*;

  logic              cs;
  logic [ADDR_W-1:0] Address;
  logic              wr_rd;
  logic [DATA_W-1:0] DOut;
  logic [DATA_W-1:0] DIn;
  logic              RDY;
  logic              mem_strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_rd;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cs, Address, wr_rd, DOut, mem_dout,
    output DIn, RDY, mem_strobe, mem_addr, mem_wr_rd, mem_din
  );

  modport master (
    output cs, Address, wr_rd, DOut, mem_dout,
    input  DIn, RDY, mem_strobe, mem_addr, mem_wr_rd, mem_din
  );

endinterface

// File: rtl/cache_data_ram.sv
// 256x8 single-port cache data RAM, synchronous write, combinational read.
//   clk     : write clock
//   we      : write enable
//   addr    : {index, offset}
//   wdata   : write byte
//   rdata_c : combinational read byte at addr
module cache_data_ram
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/cpu_req_responder.sv
// CPU-side responder: 8-line direct-mapped write-back, write-allocate cache
// with a byte-serial memory port (strobe cycle + gap cycle per byte).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : CPU request (cs/Address/wr_rd/DOut -> DIn/RDY) and memory port
//   hit_cnt, miss_cnt, wb_cnt : statistics, present only with CACHE_STATS_EN
module cpu_req_responder
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cpu_req_responder_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt,
  output logic [15:0]         wb_cnt
`endif
);

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_BYTES - 1);

  state_e             state;
  logic               cs_d;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_off;
  logic               req_wr;
  logic [DATA_W-1:0]  req_data;
  logic [OFF_W-1:0]   off;
  logic               phase;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]   tags [NUM_LINES];

  logic               hit_c;
  logic               victim_dirty_c;
  logic               ram_we_c;
  logic [OFF_W-1:0]   ram_off_c;
  logic [DATA_W-1:0]  ram_wdata_c;
  logic [DATA_W-1:0]  ram_rdata_c;

  assign hit_c          = valid[req_idx] && (tags[req_idx] == req_tag);
  assign victim_dirty_c = valid[req_idx] && dirty[req_idx];

  // RAM port steering; in WB the read runs one byte ahead so the next
  // strobe's mem_din is ready when it is issued.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_wdata_c = req_data;
    ram_off_c   = off;
    case (state)
      WB:    ram_off_c = off + OFF_W'(1);
      FILL: begin
        ram_we_c    = phase;
        ram_wdata_c = bus.mem_dout;
      end
      SERVE: begin
        ram_off_c = req_off;
        ram_we_c  = req_wr;
      end
      default: ;
    endcase
  end

  cache_data_ram u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .addr    ({req_idx, ram_off_c}),
    .wdata   (ram_wdata_c),
    .rdata_c (ram_rdata_c)
  );

  // Tag array needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == FILL && phase && off == LAST_OFF) tags[req_idx] <= req_tag;
  end

  // Main controller FSM with registered CPU and memory outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cs_d           <= 1'b0;
      req_tag        <= '0;
      req_idx        <= '0;
      req_off        <= '0;
      req_wr         <= 1'b0;
      req_data       <= '0;
      off            <= '0;
      phase          <= 1'b0;
      valid          <= '0;
      dirty          <= '0;
      bus.DIn        <= '0;
      bus.RDY        <= 1'b1;
      bus.mem_strobe <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wr_rd  <= 1'b0;
      bus.mem_din    <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      wb_cnt         <= '0;
`endif
    end else begin
      cs_d           <= bus.cs;
      bus.mem_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cs && !cs_d) begin
            req_tag  <= addr_tag(bus.Address);
            req_idx  <= addr_idx(bus.Address);
            req_off  <= addr_off(bus.Address);
            req_wr   <= bus.wr_rd;
            req_data <= bus.DOut;
            off      <= '0;
            phase    <= 1'b0;
            bus.RDY  <= 1'b0;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
`ifdef CACHE_STATS_EN
          if (hit_c) hit_cnt <= hit_cnt + 16'd1;
          else       miss_cnt <= miss_cnt + 16'd1;
          if (!hit_c && victim_dirty_c) wb_cnt <= wb_cnt + 16'd1;
`endif
          if (hit_c) begin
            state <= SERVE;
          end else if (victim_dirty_c) begin
            bus.mem_strobe <= 1'b1;
            bus.mem_wr_rd  <= 1'b1;
            bus.mem_addr   <= {tags[req_idx], req_idx, OFF_W'(0)};
            bus.mem_din    <= ram_rdata_c;
            state          <= WB;
          end else begin
            bus.mem_strobe <= 1'b1;
            bus.mem_wr_rd  <= 1'b0;
            bus.mem_addr   <= {req_tag, req_idx, OFF_W'(0)};
            state          <= FILL;
          end
        end
        WB: begin
          phase <= ~phase;
          if (phase) begin
            off            <= off + OFF_W'(1);
            bus.mem_strobe <= 1'b1;
            if (off == LAST_OFF) begin
              bus.mem_wr_rd <= 1'b0;
              bus.mem_addr  <= {req_tag, req_idx, OFF_W'(0)};
              state         <= FILL;
            end else begin
              bus.mem_addr <= {tags[req_idx], req_idx, off + OFF_W'(1)};
              bus.mem_din  <= ram_rdata_c;
            end
          end
        end
        FILL: begin
          phase <= ~phase;
          if (phase) begin
            off <= off + OFF_W'(1);
            if (off == LAST_OFF) begin
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b0;
              state          <= SERVE;
            end else begin
              bus.mem_strobe <= 1'b1;
              bus.mem_addr   <= {req_tag, req_idx, off + OFF_W'(1)};
            end
          end
        end
        SERVE: begin
          if (req_wr) dirty[req_idx] <= 1'b1;
          else        bus.DIn        <= ram_rdata_c;
          bus.RDY <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_req_responder.sv
// Directed bench for cpu_req_responder with a memory model that returns the
// low address byte on reads and a strobe log sampled on the falling edge.
module tb_cpu_req_responder;
  import cache_pkg::*;

  logic clk;
  logic rst;
  cpu_req_responder_if bus();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cpu_req_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_strobe;
  logic [15:0] log_addr [256];
  logic        log_wr   [256];
  logic [7:0]  log_din  [256];

  // Memory model and strobe log.
  always @(negedge clk) begin
    if (bus.mem_strobe) begin
      if (n_strobe < 256) begin
        log_addr[n_strobe] = bus.mem_addr;
        log_wr[n_strobe]   = bus.mem_wr_rd;
        log_din[n_strobe]  = bus.mem_din;
      end
      n_strobe = n_strobe + 1;
      if (!bus.mem_wr_rd) bus.mem_dout = bus.mem_addr[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat counts edges after E until RDY is seen high.
  // With glitch set, cs drops and rises again mid-operation with another address.
  task automatic run_req(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                         input bit glitch, output int lat);
    @(negedge clk);
    n_strobe    = 0;
    bus.cs      = 1'b1;
    bus.Address = addr;
    bus.wr_rd   = wr;
    bus.DOut    = data;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (glitch && lat == 10) bus.cs = 1'b0;
      if (glitch && lat == 12) begin
        bus.cs      = 1'b1;
        bus.Address = 16'h7744;
        bus.DOut    = 8'h5A;
      end
    end while (!bus.RDY && lat < 300);
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  // Count strobes in a range that differ from the expected sequence.
  function automatic int seq_errs(input int first, input int cnt, input logic [15:0] base,
                                  input logic wr);
    int e = 0;
    for (int i = 0; i < cnt; i++) begin
      if (log_addr[first+i] !== base + 16'(i)) e++;
      if (log_wr[first+i] !== wr) e++;
    end
    return e;
  endfunction

  int lat;
  int errs;
  int bound;

  initial begin
    n_strobe     = 0;
    rst          = 1'b0;
    bus.cs       = 1'b0;
    bus.Address  = '0;
    bus.wr_rd    = 1'b0;
    bus.DOut     = '0;
    bus.mem_dout = '0;

    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(bus.RDY), 32'd1);
    check("rst_din", 32'(bus.DIn), 32'd0);
    check("rst_strobe", 32'(bus.mem_strobe), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_strobes", 32'(n_strobe), 32'd0);
    check("idle_rdy", 32'(bus.RDY), 32'd1);

    // Cold read miss, clean victim.
    run_req(1'b0, 16'h1100, 8'h00, 1'b0, lat);
    check("cold_lat", 32'(lat), 32'd66);
    check("cold_din", 32'(bus.DIn), 32'h00);
    check("cold_nstrobe", 32'(n_strobe), 32'd32);
    check("cold_seq", 32'(seq_errs(0, 32, 16'h1100, 1'b0)), 32'd0);

    // Write hit then read hit.
    run_req(1'b1, 16'h1102, 8'hAA, 1'b0, lat);
    check("wr_hit_lat", 32'(lat), 32'd2);
    check("wr_hit_nstrobe", 32'(n_strobe), 32'd0);
    check("wr_hit_din", 32'(bus.DIn), 32'h00);
    run_req(1'b0, 16'h1102, 8'h00, 1'b0, lat);
    check("rd_hit_lat", 32'(lat), 32'd2);
    check("rd_hit_nstrobe", 32'(n_strobe), 32'd0);
    check("rd_hit_din", 32'(bus.DIn), 32'hAA);

    // Conflict miss on dirty line 0: writeback then fill.
    run_req(1'b0, 16'h3305, 8'h00, 1'b0, lat);
    check("dirty_lat", 32'(lat), 32'd130);
    check("dirty_nstrobe", 32'(n_strobe), 32'd64);
    check("wb_seq", 32'(seq_errs(0, 32, 16'h1100, 1'b1)), 32'd0);
    errs = 0;
    for (int i = 0; i < 32; i++)
      if (log_din[i] !== ((i == 2) ? 8'hAA : 8'(i))) errs++;
    check("wb_data", 32'(errs), 32'd0);
    check("wb_din_1102", 32'(log_din[2]), 32'hAA);
    check("refill_seq", 32'(seq_errs(32, 32, 16'h3300, 1'b0)), 32'd0);
    check("dirty_din", 32'(bus.DIn), 32'h05);

    // Second cs edge during a FILL is ignored.
    run_req(1'b0, 16'h5524, 8'h00, 1'b1, lat);
    check("glitch_lat", 32'(lat), 32'd66);
    check("glitch_nstrobe", 32'(n_strobe), 32'd32);
    check("glitch_seq", 32'(seq_errs(0, 32, 16'h5520, 1'b0)), 32'd0);
    check("glitch_din", 32'(bus.DIn), 32'h24);
    n_strobe = 0;
    repeat (10) @(negedge clk);
    check("glitch_after_nstrobe", 32'(n_strobe), 32'd0);
    check("glitch_after_rdy", 32'(bus.RDY), 32'd1);

    // Reset during FILL leaves the line invalid.
    @(negedge clk);
    n_strobe    = 0;
    bus.cs      = 1'b1;
    bus.Address = 16'h9966;
    bus.wr_rd   = 1'b0;
    bound = 0;
    do begin
      @(negedge clk);
      #1;
      bound++;
    end while (n_strobe < 10 && bound < 200);
    check("abort_reached", 32'(n_strobe), 32'd10);
    rst = 1'b0;
    #1;
    check("abort_rdy", 32'(bus.RDY), 32'd1);
    check("abort_strobe", 32'(bus.mem_strobe), 32'd0);
    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_req(1'b0, 16'h9966, 8'h00, 1'b0, lat);
    check("refill_lat", 32'(lat), 32'd66);
    check("refill_nstrobe", 32'(n_strobe), 32'd32);
    check("refill_seq2", 32'(seq_errs(0, 32, 16'h9960, 1'b0)), 32'd0);
    check("refill_din", 32'(bus.DIn), 32'h66);

    // Reset also invalidated line 0 (tag 0x33): re-read must miss.
    run_req(1'b0, 16'h3301, 8'h00, 1'b0, lat);
    check("post_rst_l0_lat", 32'(lat), 32'd66);
    check("post_rst_l0_din", 32'(bus.DIn), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_req_responder.md
# cpu_req_responder

CPU-side responder for the cache controller. It samples the request the CPU request generator drives (`cs`, `Address`, `wr_rd`, `DOut`), looks the address up in an 8-line direct-mapped write-back cache, and serves the request. On a miss it writes back a dirty victim line and fills the new line over a byte-serial memory port. It signals completion with `RDY` and returns read data on `DIn`.

## Interface
- `TAG_W`, default 8: tag width, `Address[15:8]`.
- `IDX_W`, default 3: index width, `Address[7:5]`; 8 lines.
- `OFF_W`, default 5: byte offset width, `Address[4:0]`; 32-byte lines.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cs`  in  1  CPU request select; held high for several cycles per request.
- `Address`  in  16  CPU byte address.
- `wr_rd`  in  1  1 = write, 0 = read.
- `DOut`  in  8  CPU write data.
- `DIn`  out  8  read data returned to the CPU.
- `RDY`  out  1  1 = idle, ready for a request.
- `mem_strobe`  out  1  one-cycle byte transfer request to memory.
- `mem_addr`  out  16  memory byte address.
- `mem_wr_rd`  out  1  1 = memory write, 0 = memory read.
- `mem_din`  out  8  byte written to memory.
- `mem_dout`  in  8  byte read from memory; valid the cycle after `mem_strobe`.

## Operation
- Request detect: register `cs` into `cs_d`. A request starts on a cycle with `cs & ~cs_d` while in IDLE. In that cycle, capture `Address`, `wr_rd` and `DOut` into request registers.
- A `cs` rising edge outside IDLE is ignored. Nothing is queued.
- States:
  - IDLE → LOOKUP on a detected request.
  - LOOKUP: a hit (valid and tag match) → SERVE. A miss with the victim line valid and dirty → WB. Any other miss → FILL.
  - WB: 32 memory writes, offsets 0..31. Address is {victim tag, index, offset}; data comes from the data RAM. Then → FILL.
  - FILL: 32 memory reads, offsets 0..31, at {req tag, index, offset}. Each `mem_dout` byte is written into the data RAM. On completion set valid=1, dirty=0, tag=req tag. Then → SERVE.
  - SERVE: a read loads `DIn` from RAM[index, offset]. A write stores the captured `DOut` to RAM and sets dirty=1; `DIn` is unchanged. Then → IDLE.
- Byte transfer: 2 cycles per byte. Cycle 1 is the strobe cycle (`mem_strobe`=1, addr, wr_rd, din valid). Cycle 2 is the gap; on reads, `mem_dout` is sampled here. A full line takes 64 cycles.
- Offset counter is 5 bits. It wraps 31→0 at the end of each WB/FILL and is reset to 0 on entry to each.
- Every miss fills the line, whether the request is a read or a write (write-allocate).

## Timing
- Reset values: `DIn`=0, `RDY`=1, `mem_strobe`=0, `mem_addr`=0, `mem_wr_rd`=0, `mem_din`=0, state IDLE, `cs_d`=0, all valid and dirty bits=0. The data RAM is not reset.
- Let edge cycle E be the clock edge that samples `cs`=1 with `cs_d`=0. The LOOKUP state and `RDY`=0 take effect from the edge after E.
- Hit: `RDY`=1 and `DIn` valid 2 cycles after E.
- Clean miss: 2 + 64 cycles after E.
- Dirty miss: 2 + 128 cycles after E.
- `mem_strobe` is never high in IDLE, LOOKUP or SERVE.
- Reset asserted mid-operation aborts any WB/FILL immediately. All lines become invalid. A partially filled line is never marked valid.
- A `cs` edge in the same cycle as the return to IDLE is ignored.

## Configuration
- `CACHE_STATS_EN` defined adds output ports:
  - `hit_cnt` (16 bits): increments once per LOOKUP hit.
  - `miss_cnt` (16 bits): increments once per LOOKUP miss.
  - `wb_cnt` (16 bits): increments once per WB entry.
  - All three wrap at 0xFFFF→0 and reset to 0.
- Without `CACHE_STATS_EN`: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `cache_pkg` holds:
  - the width constants `TAG_W`, `IDX_W`, `OFF_W`, `LINE_BYTES`=32, `NUM_LINES`=8;
  - the state enum (IDLE, LOOKUP, WB, FILL, SERVE);
  - field-extract helpers for tag, index and offset.
- Sub-module `cache_data_ram`: 256×8 single-port RAM with synchronous write and combinational read, addressed {index, offset}.
- Tag, valid and dirty arrays stay in the top level.

## Test plan
- Reset with `rst`=0 → `RDY`=1, `DIn`=0, no `mem_strobe` for 20 cycles after release with `cs`=0.
- Cold read of 0x1100 (memory model returns the low address byte) → 32 read strobes at 0x1100..0x111F. `RDY` rises at E+66, `DIn`=0x00.
- Write 0xAA to 0x1102, then read 0x1102 → both hits with `RDY` at E+2, no strobes, and `DIn`=0xAA.
- Read 0x3300 (index 0, tag 0x33) after the write:
  - 32 write strobes at 0x1100..0x111F, with `mem_din`=0xAA at 0x1102;
  - then 32 reads at 0x3300..0x331F;
  - `RDY` at E+130.
- Second `cs` rising edge during a FILL → ignored. No extra strobes, and the captured address is unchanged.
- `rst` pulsed low at the 10th fill strobe, then read the same address → full miss refill of 32 reads, proving the line was left invalid.
